rot_shift_pipe: RTL

- Parametrised, pipelined barrel rotator/shifter. Generalises the fixed-amount 32-bit rotate primitives used in the hash datapath.
- Takes a runtime amount, a direction and a mode, and returns the result after a fixed pipeline latency.
- Uses a valid/ready stream handshake with a global-stall pipeline.
- Sits between the message-schedule/compression controller and the sigma/Sigma combiners. It replaces per-constant rotate instances where a shared, time-multiplexed unit is needed.

---
 rtl/rot_shift_pkg.sv | 26 ++
 rtl/rot_shift_pipe_if.sv | 34 +++
 rtl/rot_shift_stage.sv | 57 +++++
 rtl/rot_shift_pipe.sv | 63 ++++++
 4 files changed

// File: rtl/rot_shift_pkg.sv
// Shared types for the pipelined rotator/shifter: mode encoding, direction codes and stage payload.
// The payload struct is the 32-bit hash-datapath layout; other widths pass their own type to the stages.
package rot_shift_pkg;

  typedef enum logic [1:0] {
    ROT_MODE_ROTATE,
    ROT_MODE_LSHIFT,
    ROT_MODE_ASHIFT,
    ROT_MODE_RSVD
  } rot_mode_e;

  localparam logic ROT_DIR_RIGHT = 1'b0;
  localparam logic ROT_DIR_LEFT  = 1'b1;

  localparam int ROT_W     = 32;
  localparam int ROT_TAG_W = 4;

  typedef struct packed {
    logic [ROT_W-1:0]         data;
    logic [$clog2(ROT_W)-1:0] amt;
    logic                     dir;
    rot_mode_e                mode;
    logic [ROT_TAG_W-1:0]     tag;
  } rot_pay_t;

endpackage

// File: rtl/rot_shift_pipe_if.sv
// Valid/ready stream bundle for rot_shift_pipe: request side (in_*) and result side (out_*).
// master = producer/consumer around the unit, slave = the unit itself.
interface rot_shift_pipe_if
  import rot_shift_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 4
);
  localparam int SHW = $clog2(W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [SHW-1:0]   in_amt;
  logic             in_dir;
  rot_mode_e        in_mode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_dir, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/rot_shift_stage.sv
// One pipeline stage: conditional 2^STEP rotate/shift plus enabled payload register (1 cycle, holds when en=0).
// Sign fill for arithmetic right shifts exists only with ROT_SHIFT_ARITH_EN; otherwise mode 10 is logical.
module rot_shift_stage
  import rot_shift_pkg::*;
#(
  parameter int  W     = 32,
  parameter int  STEP  = 0,
  parameter type pay_t = rot_pay_t
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic vld_i,
  input  pay_t pay_i,
  output logic vld_q,
  output pay_t pay_q
);

  localparam int S = 1 << STEP;

  pay_t         pay_d;
  logic         vld_d;
  logic [W-1:0] rot_r;
  logic [W-1:0] rot_l;

  always_comb begin
    pay_d = pay_i;
    vld_d = vld_i;
    rot_r = (pay_i.data >> S) | (pay_i.data << (W - S));
    rot_l = (pay_i.data << S) | (pay_i.data >> (W - S));
    if (pay_i.amt[STEP]) begin
      // Reserved mode shares the rotate path.
      if (pay_i.mode == ROT_MODE_ROTATE || pay_i.mode == ROT_MODE_RSVD) begin
        pay_d.data = (pay_i.dir == ROT_DIR_LEFT) ? rot_l : rot_r;
      end else if (pay_i.dir == ROT_DIR_LEFT) begin
        pay_d.data = pay_i.data << S;
`ifdef ROT_SHIFT_ARITH_EN
      end else if (pay_i.mode == ROT_MODE_ASHIFT) begin
        pay_d.data = $signed(pay_i.data) >>> S;
`endif
      end else begin
        pay_d.data = pay_i.data >> S;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q <= '0;
      vld_q <= 1'b0;
    end else if (en) begin
      pay_q <= pay_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/rot_shift_pipe.sv
// Pipelined barrel rotator/shifter, latency $clog2(W) cycles, one item per cycle; global stall when out is blocked.
// in_ready = !out_valid | out_ready; ROT_SHIFT_ARITH_EN enables sign-filled arithmetic right shifts.
module rot_shift_pipe
  import rot_shift_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst,
  rot_shift_pipe_if.slave bus
);

  localparam int SHW = $clog2(W);

  if (W < 2 || (W & (W - 1)) != 0) begin : g_w_check
    $error("rot_shift_pipe: W must be a power of two >= 2");
  end

  typedef struct packed {
    logic [W-1:0]     data;
    logic [SHW-1:0]   amt;
    logic             dir;
    rot_mode_e        mode;
    logic [TAG_W-1:0] tag;
  } pay_t;

  logic adv;
  pay_t pay [SHW+1];
  logic vld [SHW+1];

  // Every stage, bubbles included, moves only when the last stage can drain.
  assign adv          = !vld[SHW] || bus.out_ready;
  assign bus.in_ready = adv;

  assign vld[0] = bus.in_valid;
  assign pay[0] = '{data: bus.in_data, amt: bus.in_amt, dir: bus.in_dir,
                    mode: bus.in_mode, tag: bus.in_tag};

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    rot_shift_stage #(
      .W     (W),
      .STEP  (i),
      .pay_t (pay_t)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (adv),
      .vld_i (vld[i]),
      .pay_i (pay[i]),
      .vld_q (vld[i+1]),
      .pay_q (pay[i+1])
    );
  end

  assign bus.out_valid = vld[SHW];
  assign bus.out_data  = pay[SHW].data;
  assign bus.out_tag   = pay[SHW].tag;

  logic unused_ctl;
  assign unused_ctl = ^{pay[SHW].amt, pay[SHW].dir, pay[SHW].mode};

endmodule
